fir_peak_monitor: RTL

Synthesizable, parametrised peak-magnitude monitor for FIR filter outputs; the on-chip successor to the bench-side settle-then-capture-max frequency sweep. It sits on the `outp` bus of one or more `fir_filter` instances. On a `start` pulse it discards a configurable number of settling samples, then tracks per-channel maximum and minimum over a fixed window. It reports results with a one-cycle `done` pulse. Adds multi-channel support, sample-valid gating, an absolute-value mode and a loudest-channel index.

---
 rtl/fir_monitor_pkg.sv | 31 +++
 rtl/fir_peak_tracker.sv | 43 ++++
 rtl/fir_peak_monitor.sv | 128 ++++++++++++
 3 files changed

// File: rtl/fir_monitor_pkg.sv
// Shared types and helpers for the FIR peak monitor: FSM states, channel-index
// width and saturating absolute value.
package fir_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    MEASURE,
    DONE
  } mon_state_t;

  // Widest sample sat_abs handles; callers sign-extend into this width.
  localparam int unsigned ABS_MAX_W = 64;

  function automatic int unsigned ch_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // |x| for a w-bit signed value; the most-negative code maps to 2^(w-1)-1.
  function automatic logic signed [ABS_MAX_W-1:0] sat_abs(
    input logic signed [ABS_MAX_W-1:0] x,
    input int unsigned                 w
  );
    logic signed [ABS_MAX_W-1:0] most_neg;
    most_neg = -(ABS_MAX_W'(1) << (w - 1));
    if (x == most_neg) return ~most_neg;
    if (x[ABS_MAX_W-1]) return -x;
    return x;
  endfunction

endpackage

// File: rtl/fir_peak_tracker.sv
// Per-channel working max/min tracker with optional saturating abs.
// wmax/wmin present the working values including this cycle's sample.
module fir_peak_tracker
  import fir_monitor_pkg::*;
#(
  parameter int unsigned DATA_W = 40
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     first,
  input  logic                     upd,
  input  logic                     abs_en,
  input  logic signed [DATA_W-1:0] x,
  output logic signed [DATA_W-1:0] wmax,
  output logic signed [DATA_W-1:0] wmin
);

  logic signed [DATA_W-1:0] val;
  logic signed [DATA_W-1:0] max_q;
  logic signed [DATA_W-1:0] min_q;

  // Fold the current sample into the stored extremes; first sample loads both.
  always_comb begin
    val  = abs_en ? DATA_W'(sat_abs(ABS_MAX_W'(x), DATA_W)) : x;
    wmax = max_q;
    wmin = min_q;
    if (upd) begin
      if (first || (val > max_q)) wmax = val;
      if (first || (val < min_q)) wmin = val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      max_q <= '0;
      min_q <= '0;
    end else begin
      max_q <= wmax;
      min_q <= wmin;
    end
  end

endmodule

// File: rtl/fir_peak_monitor.sv
// Settle-then-measure peak monitor over NUM_CH packed FIR outputs; reports
// per-channel max/min and the loudest channel with a one-cycle done pulse.
module fir_peak_monitor
  import fir_monitor_pkg::*;
#(
  parameter int unsigned DATA_W        = 40,
  parameter int unsigned NUM_CH        = 1,
  parameter int unsigned SETTLE_CYCLES = 170,
  parameter int unsigned WINDOW_CYCLES = 2000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abs_mode,
  input  logic                       inp_valid,
  input  logic [NUM_CH*DATA_W-1:0]   inp,
  output logic                       busy,
  output logic                       done,
  output logic [NUM_CH*DATA_W-1:0]   peak_max,
  output logic [NUM_CH*DATA_W-1:0]   peak_min,
  output logic [ch_w(NUM_CH)-1:0]    max_ch
);

  localparam int unsigned CH_W    = ch_w(NUM_CH);
  localparam int unsigned CNT_MAX = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] S_LAST =
    CNT_W'((SETTLE_CYCLES == 0) ? 32'd0 : SETTLE_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] W_LAST = CNT_W'(WINDOW_CYCLES - 32'd1);

  mon_state_t               state;
  logic [CNT_W-1:0]         cnt;
  logic                     abs_lat;
  logic                     first;
  logic                     upd_c;
  logic signed [DATA_W-1:0] max_nxt [NUM_CH];
  logic signed [DATA_W-1:0] min_nxt [NUM_CH];
  logic signed [DATA_W-1:0] best_v;
  logic [CH_W-1:0]          best_ch_c;

  assign upd_c = (state == MEASURE) && inp_valid;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    fir_peak_tracker #(.DATA_W(DATA_W)) u_trk (
      .clk    (clk),
      .rst    (rst),
      .first  (first),
      .upd    (upd_c),
      .abs_en (abs_lat),
      .x      (inp[g*DATA_W +: DATA_W]),
      .wmax   (max_nxt[g]),
      .wmin   (min_nxt[g])
    );
  end

  // Loudest channel: strict greater-than keeps the lowest index on ties.
  always_comb begin
    best_v    = max_nxt[0];
    best_ch_c = '0;
    for (int unsigned i = 1; i < NUM_CH; i++) begin
      if (max_nxt[i] > best_v) begin
        best_v    = max_nxt[i];
        best_ch_c = CH_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      abs_lat  <= 1'b0;
      first    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      peak_max <= '0;
      peak_min <= '0;
      max_ch   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy    <= 1'b1;
            abs_lat <= abs_mode;
            first   <= 1'b1;
            cnt     <= '0;
            state   <= (SETTLE_CYCLES == 0) ? MEASURE : SETTLE;
          end
        end
        SETTLE: begin
          if (inp_valid) begin
            if (cnt == S_LAST) begin
              cnt   <= '0;
              state <= MEASURE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        MEASURE: begin
          if (inp_valid) begin
            first <= 1'b0;
            if (cnt == W_LAST) begin
              // Capture includes the final sample folded in this cycle.
              cnt    <= '0;
              state  <= DONE;
              done   <= 1'b1;
              max_ch <= best_ch_c;
              for (int unsigned i = 0; i < NUM_CH; i++) begin
                peak_max[i*DATA_W +: DATA_W] <= max_nxt[i];
                peak_min[i*DATA_W +: DATA_W] <= min_nxt[i];
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
